// File: rtl/lif_pkg.sv
// Shared defaults and FSM encoding for the time-multiplexed LIF scheduler.
package lif_pkg;

  localparam int W_DEF           = 8;
  localparam int THRESH_DEF      = 200;
  localparam int DECAY_SHIFT_DEF = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fsm_e;

endpackage

// File: rtl/lif_core.sv
// Combinational leaky integrate-and-fire update: leak by shift, add current,
// saturate, fire and reset when the threshold is reached.
module lif_core
  import lif_pkg::*;
#(
  parameter int W           = W_DEF,
  parameter int THRESH      = THRESH_DEF,
  parameter int DECAY_SHIFT = DECAY_SHIFT_DEF
) (
  input  logic [W-1:0] state_i,
  input  logic [W-1:0] cur_i,
  output logic [W-1:0] nxt_o,
  output logic         spk_o
);

  localparam logic [W-1:0] THR = W'(THRESH);

  logic [W:0]   sum;
  logic [W-1:0] sat;

  // One guard bit keeps the carry so saturation is exact.
  assign sum   = {1'b0, state_i >> DECAY_SHIFT} + {1'b0, cur_i};
  assign sat   = sum[W] ? '1 : sum[W-1:0];
  assign spk_o = (sat >= THR);
  assign nxt_o = spk_o ? '0 : sat;

endmodule

// File: rtl/lif_scheduler.sv
// Sweeps N_NEURONS virtual neurons through one shared lif_core per tick and
// streams spike events out over valid/ready, stalling while the slot is full.
module lif_scheduler
  import lif_pkg::*;
#(
  parameter int N_NEURONS   = 4,
  parameter int W           = W_DEF,
  parameter int THRESH      = THRESH_DEF,
  parameter int DECAY_SHIFT = DECAY_SHIFT_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tick,
  input  logic                         cur_we,
  input  logic [$clog2(N_NEURONS)-1:0] cur_addr,
  input  logic [W-1:0]                 cur_data,
  input  logic [$clog2(N_NEURONS)-1:0] rd_addr,
  output logic [W-1:0]                 rd_state,
  output logic                         spk_valid,
  input  logic                         spk_ready,
  output logic [$clog2(N_NEURONS)-1:0] spk_id,
  output logic [N_NEURONS-1:0]         spk_vec,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun
);

  localparam int AW = $clog2(N_NEURONS);
  localparam logic [AW-1:0] LAST = AW'(N_NEURONS - 1);

  fsm_e                 fsm_q, fsm_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [W-1:0]         state_q [N_NEURONS];
  logic [W-1:0]         state_d [N_NEURONS];
  logic [W-1:0]         cur_q   [N_NEURONS];
  logic [W-1:0]         cur_d   [N_NEURONS];
  logic                 spk_valid_q, spk_valid_d;
  logic [AW-1:0]        spk_id_q, spk_id_d;
  logic [N_NEURONS-1:0] spk_vec_q, spk_vec_d;
  logic                 done_q, done_d;
  logic                 overrun_q, overrun_d;
  logic [W-1:0]         rd_state_q, rd_state_d;
  logic                 proc;
  logic [W-1:0]         core_nxt;
  logic                 core_spk;

  lif_core #(
    .W           (W),
    .THRESH      (THRESH),
    .DECAY_SHIFT (DECAY_SHIFT)
  ) u_core (
    .state_i (state_q[idx_q]),
    .cur_i   (cur_q[idx_q]),
    .nxt_o   (core_nxt),
    .spk_o   (core_spk)
  );

  // A neuron is only processed when its possible event has somewhere to go.
  assign proc = (fsm_q == ST_RUN) && (!spk_valid_q || spk_ready);

  always_comb begin
    fsm_d       = fsm_q;
    idx_d       = idx_q;
    state_d     = state_q;
    cur_d       = cur_q;
    spk_valid_d = spk_valid_q;
    spk_id_d    = spk_id_q;
    spk_vec_d   = spk_vec_q;
    overrun_d   = overrun_q;
    done_d      = 1'b0;
    rd_state_d  = state_q[rd_addr];

    if (spk_valid_q && spk_ready) spk_valid_d = 1'b0;
    if (cur_we) cur_d[cur_addr] = cur_data;

    case (fsm_q)
      ST_IDLE: begin
        if (tick) begin
          fsm_d     = ST_RUN;
          idx_d     = '0;
          spk_vec_d = '0;
        end
      end
      ST_RUN: begin
        if (tick) overrun_d = 1'b1;
        if (proc) begin
          state_d[idx_q] = core_nxt;
          if (core_spk) begin
            spk_vec_d[idx_q] = 1'b1;
            spk_valid_d      = 1'b1;
            spk_id_d         = idx_q;
          end
          if (idx_q == LAST) begin
            fsm_d  = ST_IDLE;
            done_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q       <= ST_IDLE;
      idx_q       <= '0;
      spk_valid_q <= 1'b0;
      spk_id_q    <= '0;
      spk_vec_q   <= '0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      rd_state_q  <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        state_q[i] <= '0;
        cur_q[i]   <= '0;
      end
    end else begin
      fsm_q       <= fsm_d;
      idx_q       <= idx_d;
      spk_valid_q <= spk_valid_d;
      spk_id_q    <= spk_id_d;
      spk_vec_q   <= spk_vec_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
      rd_state_q  <= rd_state_d;
      for (int i = 0; i < N_NEURONS; i++) begin
        state_q[i] <= state_d[i];
        cur_q[i]   <= cur_d[i];
      end
    end
  end

  assign rd_state  = rd_state_q;
  assign spk_valid = spk_valid_q;
  assign spk_id    = spk_id_q;
  assign spk_vec   = spk_vec_q;
  assign busy      = (fsm_q == ST_RUN);
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule
